// File: rtl/debounce_filter_if.sv
// Signal bundle between a raw-input source and the debounce filter.
// The master drives the raw level and the counter clear; the slave returns the conditioned outputs.
interface debounce_filter_if #(
  parameter int GLITCH_W = 8
);
  logic                a;
  logic                glitch_clr;
  logic                clean;
  logic                changed;
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (output a, glitch_clr, input clean, changed, glitch_cnt);
  modport slave  (input a, glitch_clr, output clean, changed, glitch_cnt);
endinterface

// File: rtl/debounce_filter.sv
// Synchronizes and debounces a raw asynchronous input for the edge/pulse detectors.
// Also provides a one-cycle change strobe and a saturating count of rejected transitions.
module debounce_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  debounce_filter_if.slave  bus
);

  localparam int             CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  // STABLE/PENDING is implied by cnt: a pending change is one with a non-zero count.
  typedef enum logic { ST_STABLE, ST_PENDING } state_t;
  typedef enum logic [1:0] { EV_IDLE, EV_COUNT, EV_ACCEPT, EV_GLITCH } event_t;

  logic                a_s1, a_s2;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                clean_q, clean_d;
  logic                changed_q, changed_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  state_t              state;
  event_t              ev;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_s1      <= 1'b0;
      a_s2      <= 1'b0;
      cnt_q     <= '0;
      clean_q   <= 1'b0;
      changed_q <= 1'b0;
      glitch_q  <= '0;
    end else begin
      a_s1      <= bus.a;
      a_s2      <= a_s1;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      changed_q <= changed_d;
      glitch_q  <= glitch_d;
    end
  end

  // Next-state logic.
  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state     = (cnt_q == '0) ? ST_STABLE : ST_PENDING;
    ev        = EV_IDLE;
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    changed_d = 1'b0;
    glitch_d  = glitch_q;

    if (a_s2 != clean_q) begin
      ev = (cnt_q == LAST) ? EV_ACCEPT : EV_COUNT;
    end else if (state == ST_PENDING) begin
      ev = EV_GLITCH;
    end

    unique case (ev)
      EV_ACCEPT: begin
        clean_d   = a_s2;
        cnt_d     = '0;
        changed_d = 1'b1;
      end
      EV_COUNT:  cnt_d = cnt_q + 1'b1;
      EV_GLITCH: begin
        cnt_d = '0;
        if (glitch_q != '1) glitch_d = glitch_q + 1'b1;
      end
      default: ;
    endcase

    // A clear on the same edge as a glitch wins.
    if (bus.glitch_clr) glitch_d = '0;
  end

  // Outputs come straight from flops: no input-to-output combinational path.
  always_comb begin
    bus.clean      = clean_q;
    bus.changed    = changed_q;
    bus.glitch_cnt = glitch_q;
  end

endmodule

// File: tb/tb_debounce_filter.sv
// Self-checking bench for debounce_filter with STABLE_CYCLES = 4 and an 8-bit glitch counter.
// Expected outputs are queued when each cycle is driven and compared after the clock edge.
module tb_debounce_filter;

  logic clk;
  logic rst;

  debounce_filter_if #(.GLITCH_W(8)) bus ();

  debounce_filter #(.STABLE_CYCLES(4), .GLITCH_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       rst;
    logic       clr;
    logic       clean;
    logic       changed;
    logic [7:0] g;
  } vec_t;

  typedef struct {
    logic       clean;
    logic       changed;
    logic [7:0] g;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs, queue the expectation, take the edge, compare.
  task automatic step(input logic a_i, input logic rst_i, input logic clr_i,
                      input logic e_clean, input logic e_changed, input logic [7:0] e_g,
                      input string name);
    exp_t e;
    exp_t got;
    bus.a          = a_i;
    rst            = rst_i;
    bus.glitch_clr = clr_i;
    e.clean   = e_clean;
    e.changed = e_changed;
    e.g       = e_g;
    e.name    = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = exp_q.pop_front();
      check({got.name, ".clean"},   {7'd0, bus.clean},   {7'd0, got.clean});
      check({got.name, ".changed"}, {7'd0, bus.changed}, {7'd0, got.changed});
      check({got.name, ".glitch"},  bus.glitch_cnt,      got.g);
    end
  endtask

  // Cycle without a comparison, used for the long saturation run.
  task automatic drive(input logic a_i);
    bus.a          = a_i;
    rst            = 1'b1;
    bus.glitch_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  vec_t       tbl[18];
  logic [8:0] pat;
  int         pulses;

  initial begin
    bus.a          = 1'b0;
    bus.glitch_clr = 1'b0;
    rst            = 1'b0;

    // Reset with a held high, then rise after release, then a clean fall.
    for (int i = 0; i < 3; i++)   tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    for (int i = 3; i < 8; i++)   tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    for (int i = 11; i < 16; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

    for (int i = 0; i < 18; i++)
      step(tbl[i].a, tbl[i].rst, tbl[i].clr, tbl[i].clean, tbl[i].changed, tbl[i].g,
           $sformatf("step[%0d]", i));

    // Three-cycle pulse: rejected, one glitch on the edge a_s2 returns low.
    for (int i = 0; i < 8; i++)
      step(i < 3, 1'b1, 1'b0, 1'b0, 1'b0, (i >= 5) ? 8'd1 : 8'd0,
           $sformatf("short[%0d]", i));

    // Four-cycle pulse: accepted, then its falling edge is accepted too.
    for (int i = 0; i < 12; i++)
      step(i < 4, 1'b1, 1'b0, (i >= 5) && (i < 9), (i == 5) || (i == 9), 8'd1,
           $sformatf("exact[%0d]", i));

    // Clear the counter with the line idle.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "clr_idle");

    // Bounce: glitches at samples 1 and 4, a single accepted rise.
    pat = 9'b1_1110_1101; // bit i is the level driven on cycle i
    for (int i = 0; i < 14; i++)
      step((i < 9) ? pat[i] : 1'b1, 1'b1, 1'b0, i >= 10, i == 10,
           8'((i >= 3) + (i >= 6)), $sformatf("bounce[%0d]", i));

    // 260 one-cycle low pulses while clean is high: counter saturates.
    for (pulses = 0; pulses < 260; pulses++) begin
      drive(1'b0);
      drive(1'b1);
    end
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd255, $sformatf("sat[%0d]", i));

    // Clear coinciding with a glitch edge: clear wins.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd255, "clrg[0]");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd255, "clrg[1]");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd255, "clrg[2]");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,   "clrg[3]");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   "clrg[4]");

    // Mid-operation reset with cnt = 2: no glitch, no changed pulse afterwards.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, $sformatf("midrst[%0d]", i));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "midrst_rst");
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, $sformatf("postrst[%0d]", i));

    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
